// File: rtl/norm_arbiter.sv
// norm_arbiter: round-robin shared normaliser (lzc, left shift, exponent adjust with subnormal clamp)
module norm_arbiter #(
  parameter int NUM_ROUND_BITS = 3,
  parameter int EXP_W = 5,
  localparam int MW = 10 + NUM_ROUND_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_valid,
  output logic [1:0]       in_ready,
  input  logic [MW-1:0]    in_mant0,
  input  logic [EXP_W-1:0] in_exp0,
  input  logic [MW-1:0]    in_mant1,
  input  logic [EXP_W-1:0] in_exp1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MW-1:0]    out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_tag,
  output logic             out_zero,
  output logic             out_sub
);
  typedef enum logic [1:0] {IDLE, CALC, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic last_grant, grant, accept, tag, sub_n;
  logic [MW-1:0] mant_q, mant_n;
  logic [EXP_W-1:0] exp_q, exp_n;
  logic [7:0] lz, lz_n;
  assign grant = (&in_valid) ? ~last_grant : in_valid[1];
  assign in_ready = (state == IDLE && |in_valid) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign accept = |(in_valid & in_ready);
  assign out_valid = state == DONE;
  assign out_tag = tag;
  // sequence one transaction through the four phases; leave DONE only on output handshake
  always_comb begin
    state_n = state == IDLE ? (accept ? CALC : IDLE) :
              state == CALC ? SHIFT :
              state == SHIFT ? DONE : (out_ready ? IDLE : DONE);
  end
  // leading-zero count; the highest set bit wins because it is visited last
  always_comb begin
    lz_n = 8'(MW);
    for (int i = 0; i < MW; i++)
      if (mant_q[i]) lz_n = 8'(MW - 1 - i);
  end
  // normalise as far as the exponent allows, clamping to subnormal at exponent 0
  always_comb begin
    mant_n = mant_q;
    exp_n = '0;
    sub_n = 1'b1;
    if (mant_q == '0) begin
      sub_n = 1'b0;
    end else if (exp_q == '0) begin
      sub_n = 1'b1;
    end else if (int'(exp_q) > int'(lz)) begin
      mant_n = mant_q << lz;
      exp_n = exp_q - EXP_W'(lz);
      sub_n = 1'b0;
    end else begin
      mant_n = mant_q << (exp_q - EXP_W'(1));
    end
  end
  // state, capture on grant, lzc in CALC, result registers loaded in SHIFT
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      tag <= 1'b0;
      mant_q <= '0;
      exp_q <= '0;
      lz <= '0;
      out_mant <= '0;
      out_exp <= '0;
      out_zero <= 1'b0;
      out_sub <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        mant_q <= grant ? in_mant1 : in_mant0;
        exp_q <= grant ? in_exp1 : in_exp0;
        tag <= grant;
        last_grant <= grant;
      end
      if (state == CALC) lz <= lz_n;
      if (state == SHIFT) begin
        out_mant <= mant_n;
        out_exp <= exp_n;
        out_zero <= mant_q == '0;
        out_sub <= sub_n;
      end
    end
  end
endmodule

// File: tb/tb_norm_arbiter.sv
// tb_norm_arbiter: directed vector table plus arbitration, backpressure and reset sequences
module tb_norm_arbiter;
  localparam int MW = 13;
  localparam int EW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] in_valid = '0;
  logic [1:0] in_ready;
  logic [MW-1:0] in_mant0 = '0, in_mant1 = '0;
  logic [EW-1:0] in_exp0 = '0, in_exp1 = '0;
  logic out_valid, out_ready = 1'b0, out_tag, out_zero, out_sub;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    int r;
    logic [MW-1:0] m;
    logic [EW-1:0] e;
    logic [MW-1:0] om;
    logic [EW-1:0] oe;
    logic z;
    logic s;
  } vec_t;
  vec_t v[10];

  norm_arbiter #(.NUM_ROUND_BITS(3), .EXP_W(EW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mant0(in_mant0), .in_exp0(in_exp0), .in_mant1(in_mant1), .in_exp1(in_exp1),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
    .out_tag(out_tag), .out_zero(out_zero), .out_sub(out_sub)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // called just after a negedge; returns at the negedge after the accept edge (CALC)
  task automatic issue(input int r, input logic [MW-1:0] m, input logic [EW-1:0] e);
    int k = 0;
    if (r == 0) begin in_mant0 = m; in_exp0 = e; end
    else begin in_mant1 = m; in_exp1 = e; end
    in_valid[r] = 1'b1;
    #1;
    while (!in_ready[r] && k < 10) begin @(negedge clk); #1; k++; end
    chk("grant", 32'(in_ready[r]), 1);
    @(negedge clk);
    in_valid[r] = 1'b0;
  endtask

  // from CALC negedge, checks latency and leaves us at the DONE negedge
  task automatic to_done();
    chk("calc_valid", 32'(out_valid), 0);
    chk("calc_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("shift_valid", 32'(out_valid), 0);
    chk("shift_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("done_valid", 32'(out_valid), 1);
  endtask

  initial begin
    v[0] = '{0, 13'h0400, 5'd10, 13'h1000, 5'd8, 1'b0, 1'b0};
    v[1] = '{1, 13'h0001, 5'd5, 13'h0010, 5'd0, 1'b0, 1'b1};
    v[2] = '{0, 13'h0000, 5'd7, 13'h0000, 5'd0, 1'b1, 1'b0};
    v[3] = '{1, 13'h0020, 5'd0, 13'h0020, 5'd0, 1'b0, 1'b1};
    v[4] = '{0, 13'h0400, 5'd2, 13'h0800, 5'd0, 1'b0, 1'b1};
    v[5] = '{1, 13'h0400, 5'd3, 13'h1000, 5'd1, 1'b0, 1'b0};
    v[6] = '{0, 13'h1fff, 5'd31, 13'h1fff, 5'd31, 1'b0, 1'b0};
    v[7] = '{1, 13'h0003, 5'd12, 13'h1800, 5'd1, 1'b0, 1'b0};
    v[8] = '{0, 13'h0003, 5'd11, 13'h0c00, 5'd0, 1'b0, 1'b1};
    v[9] = '{1, 13'h0000, 5'd0, 13'h0000, 5'd0, 1'b1, 1'b0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_mant", 32'(out_mant), 0);
    chk("rst_exp", 32'(out_exp), 0);
    chk("rst_tag", 32'(out_tag), 0);
    chk("rst_zero", 32'(out_zero), 0);
    chk("rst_sub", 32'(out_sub), 0);
    chk("rst_ready", 32'(in_ready), 0);
    // arbitration: both held, out_ready high, tags must alternate starting at 0
    in_mant0 = 13'h0100; in_exp0 = 5'd20;
    in_mant1 = 13'h0200; in_exp1 = 5'd20;
    out_ready = 1'b1;
    in_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("arb_ready", 32'(in_ready), (t % 2 == 0) ? 1 : 2);
      repeat (2) begin
        @(negedge clk);
        chk("arb_busy_ready", 32'(in_ready), 0);
      end
      @(negedge clk);
      chk("arb_done_ready", 32'(in_ready), 0);
      chk("arb_valid", 32'(out_valid), 1);
      chk("arb_tag", 32'(out_tag), 32'(t % 2));
      @(negedge clk);
    end
    in_valid = 2'b00;
    out_ready = 1'b0;
    @(negedge clk);
    // vector table
    for (int i = 0; i < 10; i++) begin
      issue(v[i].r, v[i].m, v[i].e);
      to_done();
      chk($sformatf("v%0d_mant", i), 32'(out_mant), 32'(v[i].om));
      chk($sformatf("v%0d_exp", i), 32'(out_exp), 32'(v[i].oe));
      chk($sformatf("v%0d_tag", i), 32'(out_tag), 32'(v[i].r));
      chk($sformatf("v%0d_zero", i), 32'(out_zero), 32'(v[i].z));
      chk($sformatf("v%0d_sub", i), 32'(out_sub), 32'(v[i].s));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("v%0d_drop", i), 32'(out_valid), 0);
    end
    // backpressure: hold in DONE with both requesting
    issue(0, 13'h0400, 5'd10);
    to_done();
    in_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_mant", 32'(out_mant), 32'h1000);
      chk("bp_exp", 32'(out_exp), 8);
      chk("bp_tag", 32'(out_tag), 0);
      chk("bp_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("bp_after_valid", 32'(out_valid), 0);
    chk("bp_next_grant", 32'(in_ready), 2);
    in_valid = 2'b00;
    @(negedge clk);
    chk("bp_idle_valid", 32'(out_valid), 0);
    // reset while in SHIFT
    issue(1, 13'h0001, 5'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rmid_valid", 32'(out_valid), 0);
    chk("rmid_mant", 32'(out_mant), 0);
    chk("rmid_sub", 32'(out_sub), 0);
    @(negedge clk);
    chk("rmid_idle_valid", 32'(out_valid), 0);
    in_valid = 2'b11;
    #1;
    chk("rmid_grant", 32'(in_ready), 1);
    in_valid = 2'b00;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
